handle_fifo_ctrl: RTL and testbench
===================================

Name: handle_fifo_ctrl

Overview:
- Pointer/flow-control engine that drives the handle_fifo dual-port RAM from both ends.
- Accepts handles on a valid/ready push stream and writes them into the RAM.
- Reads them back, covering the RAM's 1-cycle registered read latency with a 2-entry prefetch output buffer.
- Presents a valid/ready pop stream that sustains 1 handle/cycle.

Parameters:
- DATA_WIDTH, 40, handle width; must match the RAM.
- ADDR_WIDTH, 4, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all contents; same effect as reset.
- in_valid  in  1  push request.
- in_data  in  DATA_WIDTH  handle to push.
- in_ready  out  1  push accept.
- out_valid  out  1  head handle available.
- out_data  out  DATA_WIDTH  head handle.
- out_ready  in  1  pop accept from consumer.
- level  out  ADDR_WIDTH+2  total stored handles: RAM + in-flight + output buffer.
- ram_we  out  1  RAM write enable.
- ram_write_addr  out  ADDR_WIDTH  RAM write address.
- ram_data  out  DATA_WIDTH  RAM write data.
- ram_read_addr  out  ADDR_WIDTH  RAM read address.
- ram_q  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_read_addr.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high.
- State registers:
  - wr_ptr, rd_ptr: ADDR_WIDTH+1 bits each; the MSB is the wrap bit.
  - inflight: 1 bit.
  - obuf: 2 entries.
  - ocnt: 0..2.
- Reset/flush (reset has priority when both are high), applied at the clock edge:
  - wr_ptr=rd_ptr=0, inflight=0, ocnt=0.
  - Outputs: in_ready=1 (after reset, combinational), out_valid=0, level=0, ram_we=0, out_data=0.
  - RAM contents are not cleared.
  - A push or pop presented in the same cycle as reset/flush is discarded.
- Derived terms:
  - ram_cnt = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
  - empty_ram = (ram_cnt==0).
  - full_ram = (ram_cnt==DEPTH).
- Push side:
  - in_ready = !full_ram.
  - push = in_valid & in_ready.
  - ram_we = push; ram_write_addr = wr_ptr[ADDR_WIDTH-1:0]; ram_data = in_data; all combinational.
  - wr_ptr increments on push.
- Read issue:
  - pop = out_valid & out_ready.
  - issue = !empty_ram & (ocnt + inflight - pop < 2).
  - ram_read_addr = rd_ptr[ADDR_WIDTH-1:0].
  - rd_ptr increments on issue.
  - inflight <= issue.
- Read/write collision: never reads a slot written in the same cycle. A slot becomes readable only after the edge that commits it (rd_ptr != wr_ptr), so the RAM's old-data-on-collision behaviour is never exposed.
- Capture: when inflight=1, ram_q is appended to obuf that cycle.
- Output buffer:
  - out_valid = (ocnt!=0); out_data = obuf head.
  - Pop and capture in the same cycle: head shifts out and the new word enters, so ocnt is unchanged.
  - Overflow of obuf is impossible by the issue rule. The bench asserts this.
- Ordering: strict FIFO order across RAM wrap-around.
- Latency:
  - Push accepted at edge E0 → read issued in the cycle after E0 → ram_q valid after E1 → captured at E2 → out_valid=1 after E2, i.e. 3 cycles when the FIFO is empty.
  - Throughput is 1 push and 1 pop per cycle, sustained and simultaneous.
- Capacity: in_ready depends only on RAM occupancy, so up to DEPTH+2 handles can be held (DEPTH in RAM, 2 in obuf).
  - level = ram_cnt + inflight + ocnt, range 0..DEPTH+2.
- Push when full_ram: not accepted. Push with in_valid=0: no RAM write.
- out_valid stays asserted and out_data stays stable until popped.

Test Plan:
- Reset, then push 0x01 (single cycle) → out_valid rises exactly 3 cycles after the accept edge with out_data=0x01; level goes 1→1→1→1 and returns to 0 after the pop.
- out_ready=0, push 20 handles 0x100..0x113 with DEPTH=16 → 18 accepted (16 RAM + 2 obuf); in_ready=0 afterwards; level=18.
- Continue the previous scenario with out_ready=1 → pops return 0x100..0x111 in order; in_ready returns 1 one cycle after the first pop frees a RAM slot.
- Continuous push and pop every cycle for 100 handles (forces pointer wrap ≥6 times) → no gaps in out_valid after startup; data in order; level constant at 3.
- Random in_valid/out_ready at 50% for 10k cycles against a reference queue model → order and count match; obuf never exceeds 2; in_ready never 1 when ram_cnt=DEPTH.
- Flush asserted with level=7 while push and pop are active → next cycle level=0, out_valid=0, in_ready=1; next push 0xAB appears 3 cycles later, not stale data.

Source files
------------

// File: rtl/handle_fifo_if.sv
// handle_fifo_if: bundles the push stream, pop stream, level report and
// the RAM-side port of the handle FIFO controller.
//   slave  : the controller's view (takes pushes, offers pops, drives the RAM)
//   master : the environment's view (producer, consumer and RAM model)
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; the source holds data stable while valid is high and ready
// is low, and ready may depend on state only, never on valid.
interface handle_fifo_if #(
   parameter int DATA_WIDTH = 40,
   parameter int ADDR_WIDTH = 4
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   logic [ADDR_WIDTH+1:0] level;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_write_addr;
   logic [DATA_WIDTH-1:0] ram_data;
   logic [ADDR_WIDTH-1:0] ram_read_addr;
   logic [DATA_WIDTH-1:0] ram_q;

   modport slave (
      input  in_valid, in_data, out_ready, ram_q,
      output in_ready, out_valid, out_data, level,
             ram_we, ram_write_addr, ram_data, ram_read_addr
   );

   modport master (
      output in_valid, in_data, out_ready, ram_q,
      input  in_ready, out_valid, out_data, level,
             ram_we, ram_write_addr, ram_data, ram_read_addr
   );
endinterface

// File: rtl/handle_fifo_ctrl.sv
// handle_fifo_ctrl: pointer and flow-control engine for the handle_fifo
// dual-port RAM. Pushes are written straight into the RAM; reads are issued
// ahead of demand and the RAM's one-cycle read latency is hidden behind a
// two-entry output buffer so the pop side sustains one handle per cycle.
// Ports:
//   clk    : single clock
//   reset  : synchronous, active-high; wins over flush
//   flush  : synchronous clear of all stored handles (RAM contents untouched)
//   bus    : handle_fifo_if.slave -- push stream (in_*), pop stream (out_*),
//            occupancy (level) and the RAM write/read port (ram_*)
module handle_fifo_ctrl #(
   parameter int DATA_WIDTH = 40,
   parameter int ADDR_WIDTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   handle_fifo_if.slave   bus
);
   localparam int PW    = ADDR_WIDTH + 1;
   localparam int LW    = ADDR_WIDTH + 2;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] obuf [0:1];
   logic [1:0]            ocnt;

   logic [PW-1:0]         ram_cnt;
   logic                  empty_ram;
   logic                  full_ram;
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic [2:0]            committed;
   logic [1:0]            kept;

   // Pointers carry a wrap bit, so the difference is the RAM occupancy
   // even across wrap-around.
   assign ram_cnt   = wr_ptr - rd_ptr;
   assign empty_ram = (ram_cnt == '0);
   assign full_ram  = (ram_cnt == PW'(DEPTH));

   assign bus.in_ready = !full_ram;
   assign push         = bus.in_valid && !full_ram;
   assign pop          = bus.out_valid && bus.out_ready;

   // Words already owned by the output side after this edge: buffered plus
   // the read in flight, minus the one leaving. Only issue a read if there
   // will be a free buffer slot when its data arrives.
   assign committed = 3'(ocnt) + 3'(inflight) - 3'(pop);
   assign issue     = !empty_ram && (committed < 3'd2);

   // Entries remaining after this cycle's pop; a captured word lands here.
   assign kept = ocnt - 2'(pop);

   assign bus.ram_we         = push;
   assign bus.ram_write_addr = wr_ptr[ADDR_WIDTH-1:0];
   assign bus.ram_data       = bus.in_data;
   // A slot is only readable once its write edge has passed (rd_ptr lags
   // wr_ptr), so this address never collides with a same-cycle write.
   assign bus.ram_read_addr  = rd_ptr[ADDR_WIDTH-1:0];

   assign bus.out_valid = (ocnt != 2'd0);
   assign bus.out_data  = obuf[0];
   assign bus.level     = LW'(ram_cnt) + LW'(inflight) + LW'(ocnt);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= 1'b0;
         ocnt     <= 2'd0;
         obuf[0]  <= '0;
         obuf[1]  <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + PW'(1);
         if (issue) rd_ptr <= rd_ptr + PW'(1);
         inflight <= issue;
         if (pop) obuf[0] <= obuf[1];
         // Later assignment wins when pop and capture both target slot 0.
         if (inflight) obuf[kept[0]] <= bus.ram_q;
         ocnt <= kept + 2'(inflight);
      end
   end
endmodule

// File: tb/tb_handle_fifo_ctrl.sv
module tb_handle_fifo_ctrl;
  localparam int DW    = 40;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  handle_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  handle_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // Dual-port RAM model: registered read, old data on collision.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_write_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_read_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  bit chk_inv  = 1'b0;

  logic          s_in_ready;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [AW+1:0] s_level;
  logic          s_ram_we;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: sample at negedge (state after the previous edge),
  // score the handshakes that the next edge will complete, then step to
  // just after that edge so the caller can change inputs.
  task automatic cycle();
    logic [DW-1:0] e;
    @(negedge clk);
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    s_out_data  = bus.out_data;
    s_level     = bus.level;
    s_ram_we    = bus.ram_we;
    if (!reset) begin
      check("level", 64'(s_level), 64'(exp_q.size()));
      check("ram_we", 64'(s_ram_we), 64'(bus.in_valid && s_in_ready));
    end
    if (chk_inv) begin
      check("level_max", 64'(s_level <= (DEPTH + 2)), 64'(1));
      check("full_blocks", 64'(!(s_level == (DEPTH + 2) && s_in_ready)), 64'(1));
      check("ready_below_depth", 64'((s_level < DEPTH) ? s_in_ready : 1'b1), 64'(1));
    end
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (s_out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("pop_underflow", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("pop_data", 64'(s_out_data), 64'(e));
        end
        n_pop++;
      end
      if (bus.in_valid && s_in_ready) begin
        exp_q.push_back(bus.in_data);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      cycle();
      if (exp_q.size() == 0 && s_level == 0) break;
    end
    cycle();
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    check("drain_level", 64'(s_level), 64'(0));
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {8'($urandom), $urandom};
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int idx;
    int p0;
    int sent;

    reset = 1'b1;
    bus.in_data = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_level", 64'(bus.level), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_ram_we", 64'(bus.ram_we), 64'(0));
    @(posedge clk);
    #1;

    // Single push: out_valid three edges after the accept edge
    bus.in_valid = 1'b1;
    bus.in_data  = 40'h01;
    cycle();
    check("t1_accept", 64'(s_in_ready), 64'(1));
    bus.in_valid = 1'b0;
    cycle();
    check("t1_e0_valid", 64'(s_out_valid), 64'(0));
    check("t1_e0_level", 64'(s_level), 64'(1));
    cycle();
    check("t1_e1_valid", 64'(s_out_valid), 64'(0));
    check("t1_e1_level", 64'(s_level), 64'(1));
    cycle();
    check("t1_e2_valid", 64'(s_out_valid), 64'(1));
    check("t1_e2_data", 64'(s_out_data), 64'h01);
    check("t1_e2_level", 64'(s_level), 64'(1));
    cycle();
    check("t1_hold_valid", 64'(s_out_valid), 64'(1));
    check("t1_hold_data", 64'(s_out_data), 64'h01);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    cycle();
    check("t1_after_pop_level", 64'(s_level), 64'(0));
    check("t1_after_pop_valid", 64'(s_out_valid), 64'(0));

    // Fill with consumer stalled: DEPTH in RAM + 2 in the output buffer
    idx = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 40'h100;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (bus.in_valid && s_in_ready) begin
        idx++;
        if (idx < 20) bus.in_data = 40'h100 + 40'(idx);
        else bus.in_valid = 1'b0;
      end
    end
    check("t2_accepted", 64'(idx), 64'(DEPTH + 2));
    check("t2_in_ready", 64'(s_in_ready), 64'(0));
    check("t2_level", 64'(s_level), 64'(DEPTH + 2));
    check("t2_head", 64'(s_out_data), 64'h100);

    // Release consumer: first pop frees a RAM slot one cycle later
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    p0 = n_pop;
    cycle();
    check("t3_first_pop_ready", 64'(s_in_ready), 64'(0));
    cycle();
    check("t3_ready_back", 64'(s_in_ready), 64'(1));
    drain(40);
    check("t3_pop_count", 64'(n_pop - p0), 64'(DEPTH + 2));

    // Streaming: push and pop every cycle, 100 handles
    sent = 0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data   = rand_data();
    for (int c = 0; c <= 100; c++) begin
      cycle();
      if (c >= 3 && c < 100) begin
        check("t4_no_gap", 64'(s_out_valid), 64'(1));
        check("t4_level3", 64'(s_level), 64'(3));
      end
      if (bus.in_valid && s_in_ready) begin
        sent++;
        if (sent == 100) bus.in_valid = 1'b0;
        else bus.in_data = rand_data();
      end
    end
    check("t4_sent", 64'(sent), 64'(100));
    drain(20);

    // Random traffic against the queue model
    chk_inv = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      cycle();
      // Hold data while a push is pending; otherwise draw a new request.
      if (!bus.in_valid || s_in_ready) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = rand_data();
      end
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    drain(40);
    chk_inv = 1'b0;

    // Flush while push and pop are active
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.in_data = rand_data();
      cycle();
    end
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 40'h55;
    bus.out_ready = 1'b1;
    cycle();
    check("t6_pre_level", 64'(s_level), 64'(7));
    check("t6_pre_valid", 64'(s_out_valid), 64'(1));
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cycle();
    check("t6_level0", 64'(s_level), 64'(0));
    check("t6_valid0", 64'(s_out_valid), 64'(0));
    check("t6_ready1", 64'(s_in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = 40'hAB;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    check("t6_e0_valid", 64'(s_out_valid), 64'(0));
    cycle();
    check("t6_e1_valid", 64'(s_out_valid), 64'(0));
    cycle();
    check("t6_e2_valid", 64'(s_out_valid), 64'(1));
    check("t6_e2_data", 64'(s_out_data), 64'hAB);
    drain(10);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
